shifter2d_piso: RTL

- Parallel-in / serial-out word shifter; the transmit-side counterpart of the SHIFTER2D serial-in delay line.
- Captures PROFUNDIDAD words of TAMANYO bits in one cycle, then presents them on SS one word per enabled clock, word 0 first.
- Feeds a SHIFTER2D chain or any consumer that samples on enable.
- Word i of the load bus is PE[(i+1)*TAMANYO-1 : i*TAMANYO].

---
 rtl/shifter2d_piso.sv | 70 +++++++
 1 files changed

// File: rtl/shifter2d_piso.sv
// Parallel-in / serial-out word shifter, word 0 first, one word per enable.
// Optional macro SHIFTER2D_PISO_RECIRC_EN rotates words instead of zero-filling.
module shifter2d_piso #(
  parameter int TAMANYO     = 8,
  parameter int PROFUNDIDAD = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PROFUNDIDAD*TAMANYO-1:0] PE,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic                           enable,
  output logic [TAMANYO-1:0]             SS,
  output logic                           SS_valid,
  output logic                           last
);

  localparam int CW = $clog2(PROFUNDIDAD + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state;
  logic [TAMANYO-1:0] stages [PROFUNDIDAD];
  logic [CW-1:0]      count;
  logic [TAMANYO-1:0] fill;
  logic               final_word;
  logic               do_load;
  logic               do_shift;

  assign final_word = (state == SHIFT) && (count == CW'(1));
  assign load_ready = (state == IDLE) || (final_word && enable);
  assign do_load    = load_valid && load_ready;
  assign do_shift   = (state == SHIFT) && enable;

`ifdef SHIFTER2D_PISO_RECIRC_EN
  // Rotation: after PROFUNDIDAD shifts the block is back in load order.
  assign fill = stages[0];
`else
  assign fill = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      for (int i = 0; i < PROFUNDIDAD; i++)
        stages[i] <= '0;
    end else if (do_load) begin
      state <= SHIFT;
      count <= CW'(PROFUNDIDAD);
      for (int i = 0; i < PROFUNDIDAD; i++)
        stages[i] <= PE[i*TAMANYO +: TAMANYO];
    end else if (do_shift) begin
      for (int i = 0; i < PROFUNDIDAD - 1; i++)
        stages[i] <= stages[i+1];
      stages[PROFUNDIDAD-1] <= fill;
      count <= count - CW'(1);
      if (final_word)
        state <= IDLE;
    end
  end

  assign SS       = stages[0];
  assign SS_valid = (state == SHIFT);
  assign last     = final_word;

endmodule
